// File: rtl/ram_port_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for the RAM port arbiter           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_RESP = 1'b1
   } arb_state_e;

   localparam logic       REQ_IFETCH = 1'b0;
   localparam logic       REQ_DATA   = 1'b1;
   localparam logic [3:0] FULL_BE    = 4'b1111;

   // Word index lies beyond the RAM when addr[31:2] >= depth.
   function automatic logic addr_oor(input logic [31:0] addr, input int unsigned depth);
      return {2'b00, addr[31:2]} >= depth;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | ram_port_arbiter_if : fetch port, data port and RAM-side bus of the arbiter |
// | Revision            : 1.0 - initial release                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ram_port_arbiter_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);
   localparam int BYTES = DATA_WIDTH / 8;

   logic                     i_valid;
   logic                     i_ready;
   logic [ADDRESS_WIDTH-1:0] i_addr;
   logic                     i_rvalid;
   logic [DATA_WIDTH-1:0]    i_rdata;
   logic                     i_err;

   logic                     d_valid;
   logic                     d_ready;
   logic [ADDRESS_WIDTH-1:0] d_addr;
   logic                     d_we;
   logic [BYTES-1:0]         d_be;
   logic [DATA_WIDTH-1:0]    d_wdata;
   logic                     d_rvalid;
   logic [DATA_WIDTH-1:0]    d_rdata;
   logic                     d_err;

   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [BYTES-1:0]         mem_be;
   logic [DATA_WIDTH-1:0]    mem_wdata;
   logic                     mem_we;
   logic [DATA_WIDTH-1:0]    mem_rdata;

   modport slave (
      input  i_valid, i_addr,
      input  d_valid, d_addr, d_we, d_be, d_wdata,
      input  mem_rdata,
      output i_ready, i_rvalid, i_rdata, i_err,
      output d_ready, d_rvalid, d_rdata, d_err,
      output mem_addr, mem_be, mem_wdata, mem_we
   );

   modport master (
      output i_valid, i_addr,
      output d_valid, d_addr, d_we, d_be, d_wdata,
      output mem_rdata,
      input  i_ready, i_rvalid, i_rdata, i_err,
      input  d_ready, d_rvalid, d_rdata, d_err,
      input  mem_addr, mem_be, mem_wdata, mem_we
   );

endinterface

`default_nettype wire

// File: rtl/ram_port_arbiter_pick2.sv
// +----------------------------------------------------------------------------+
// | arb_pick2 : combinational two-way pick, one-hot grant {data, fetch}         |
// |             ARB_RR_EN selects round-robin, otherwise data has priority.     |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module arb_pick2
   import mem_arb_pkg::*;
(
   input  logic       fetch_valid,
   input  logic       data_valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

`ifdef ARB_RR_EN
   always_comb begin
      grant = 2'b00;
      if (fetch_valid && data_valid) begin
         grant = (last_grant == REQ_DATA) ? 2'b01 : 2'b10;
      end else if (data_valid) begin
         grant = 2'b10;
      end else if (fetch_valid) begin
         grant = 2'b01;
      end
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      grant = 2'b00;
      if (data_valid) begin
         grant = 2'b10;
      end else if (fetch_valid) begin
         grant = 2'b01;
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | ram_port_arbiter : shares one byte-enabled block RAM between fetch and      |
// |                    load/store ports; optional macro ARB_RR_EN (round-robin).|
// | Revision         : 1.0 - initial release                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DEPTH         = 50,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   ram_port_arbiter_if.slave   bus
);

   localparam int BYTES = DATA_WIDTH / 8;

   arb_state_e               state_q, state_d;
   logic                     winner_q, winner_d;
   logic                     err_q, err_d;
   logic                     last_q, last_d;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;

   logic [1:0]               grant;
   logic [ADDRESS_WIDTH-1:0] sel_addr;
   logic                     sel_oor;
   logic [DATA_WIDTH-1:0]    resp_data;

   logic                     i_ready, i_rvalid, i_err;
   logic                     d_ready, d_rvalid, d_err;
   logic [DATA_WIDTH-1:0]    i_rdata, d_rdata;
   logic                     mem_we;
   logic [BYTES-1:0]         mem_be;

   arb_pick2 u_pick (
      .fetch_valid (bus.i_valid),
      .data_valid  (bus.d_valid),
      .last_grant  (last_q),
      .grant       (grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         winner_q    <= REQ_DATA;
         err_q       <= 1'b0;
         last_q      <= REQ_DATA;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         winner_q    <= winner_d;
         err_q       <= err_d;
         last_q      <= last_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      winner_d    = winner_q;
      err_d       = err_q;
      last_d      = last_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_ready     = 1'b0;
      i_rvalid    = 1'b0;
      i_rdata     = '0;
      i_err       = 1'b0;
      d_ready     = 1'b0;
      d_rvalid    = 1'b0;
      d_rdata     = '0;
      d_err       = 1'b0;
      mem_we      = 1'b0;
      mem_be      = '0;
      sel_addr    = grant[1] ? bus.d_addr : bus.i_addr;
      sel_oor     = addr_oor(sel_addr, DEPTH);
      resp_data   = err_q ? '0 : bus.mem_rdata;

      case (state_q)
         ARB_IDLE: begin
            if (grant != 2'b00) begin
               winner_d   = grant[1] ? REQ_DATA : REQ_IFETCH;
               last_d     = winner_d;
               err_d      = sel_oor;
               mem_addr_d = sel_addr;
               state_d    = ARB_RESP;
               // Out-of-range accesses still handshake but never reach the RAM.
               if (grant[1]) begin
                  d_ready     = 1'b1;
                  mem_wdata_d = bus.d_wdata;
                  mem_we      = bus.d_we & ~sel_oor;
                  mem_be      = sel_oor ? '0 : bus.d_be;
               end else begin
                  i_ready = 1'b1;
                  mem_be  = sel_oor ? '0 : FULL_BE;
               end
            end
         end
         ARB_RESP: begin
            state_d = ARB_IDLE;
            if (winner_q == REQ_DATA) begin
               d_rvalid = 1'b1;
               d_rdata  = resp_data;
               d_err    = err_q;
            end else begin
               i_rvalid = 1'b1;
               i_rdata  = resp_data;
               i_err    = err_q;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   assign bus.i_ready   = i_ready;
   assign bus.i_rvalid  = i_rvalid;
   assign bus.i_rdata   = i_rdata;
   assign bus.i_err     = i_err;
   assign bus.d_ready   = d_ready;
   assign bus.d_rvalid  = d_rvalid;
   assign bus.d_rdata   = d_rdata;
   assign bus.d_err     = d_err;
   assign bus.mem_addr  = mem_addr_d;
   assign bus.mem_wdata = mem_wdata_d;
   assign bus.mem_we    = mem_we;
   assign bus.mem_be    = mem_be;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_ram_port_arbiter : directed bench with a read-before-write RAM model     |
// | Revision            : 1.0 - initial release                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ram_port_arbiter;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   ram_port_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

   ram_port_arbiter #(
      .DEPTH         (50),
      .ADDRESS_WIDTH (32),
      .DATA_WIDTH    (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Registered-output RAM: read word reflects contents before this edge's write.
   logic [31:0] ram [0:63];
   logic [31:0] ram_q = '0;
   assign bus.mem_rdata = ram_q;

   always @(posedge clk) begin
      ram_q <= ram[bus.mem_addr[7:2]];
      for (int b = 0; b < 4; b++) begin
         if (bus.mem_we && bus.mem_be[b])
            ram[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
   end

   task automatic d_xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output int waited, output logic [31:0] maddr,
                         output logic mwe, output logic [3:0] mbe, output logic rv,
                         output logic [31:0] rd, output logic er);
      @(posedge clk); #1;
      bus.d_valid = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_be = be; bus.d_wdata = wd;
      waited = 0;
      @(negedge clk);
      while (bus.d_ready !== 1'b1 && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      maddr = bus.mem_addr; mwe = bus.mem_we; mbe = bus.mem_be;
      @(posedge clk); #1;
      bus.d_valid = 1'b0;
      @(negedge clk);
      rv = bus.d_rvalid; rd = bus.d_rdata; er = bus.d_err;
   endtask

   task automatic i_xfer(input logic [31:0] addr, output int waited, output logic [31:0] maddr,
                         output logic mwe, output logic [3:0] mbe, output logic rv,
                         output logic [31:0] rd, output logic er);
      @(posedge clk); #1;
      bus.i_valid = 1'b1; bus.i_addr = addr;
      waited = 0;
      @(negedge clk);
      while (bus.i_ready !== 1'b1 && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      maddr = bus.mem_addr; mwe = bus.mem_we; mbe = bus.mem_be;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      @(negedge clk);
      rv = bus.i_rvalid; rd = bus.i_rdata; er = bus.i_err;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({bus.i_ready, bus.d_ready} !== 2'b00) begin
         bad++; $display("FAIL reset_ready: got %b want 00", {bus.i_ready, bus.d_ready});
      end
      total++;
      if ({bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err} !== 4'b0000) begin
         bad++; $display("FAIL reset_rvalid_err: got %b want 0000",
                         {bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err});
      end
      total++;
      if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
         bad++; $display("FAIL reset_rdata: got i=%h d=%h want 0", bus.i_rdata, bus.d_rdata);
      end
      total++;
      if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_be !== 4'h0 || bus.mem_we !== 1'b0) begin
         bad++; $display("FAIL reset_mem: got addr=%h wdata=%h be=%b we=%b want all 0",
                         bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.mem_we);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_fetch_read();
      int w; logic [31:0] ma, rd; logic mwe, rv, er; logic [3:0] mbe;
      d_xfer(1'b1, 32'h0C, 4'b1111, 32'hDEADBEEF, w, ma, mwe, mbe, rv, rd, er);
      total++;
      if (w != 0 || mwe !== 1'b1 || mbe !== 4'b1111 || ma !== 32'h0C || rv !== 1'b1 || er !== 1'b0) begin
         bad++; $display("FAIL preload_write: got wait=%0d we=%b be=%b addr=%h rv=%b err=%b want 0 1 1111 0c 1 0",
                         w, mwe, mbe, ma, rv, er);
      end
      i_xfer(32'h0C, w, ma, mwe, mbe, rv, rd, er);
      total++;
      if (w != 0 || ma !== 32'h0C || mwe !== 1'b0 || mbe !== 4'b1111) begin
         bad++; $display("FAIL fetch_grant: got wait=%0d addr=%h we=%b be=%b want 0 0c 0 1111", w, ma, mwe, mbe);
      end
      total++;
      if (rv !== 1'b1 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
         bad++; $display("FAIL fetch_resp: got rv=%b rdata=%h err=%b want 1 deadbeef 0", rv, rd, er);
      end
      @(negedge clk);
      total++;
      if (bus.mem_addr !== 32'h0C || bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0 || bus.i_rvalid !== 1'b0) begin
         bad++; $display("FAIL idle_hold: got addr=%h we=%b be=%b rv=%b want 0c 0 0000 0",
                         bus.mem_addr, bus.mem_we, bus.mem_be, bus.i_rvalid);
      end
   endtask

   task automatic test_partial_store();
      int w; logic [31:0] ma, rd; logic mwe, rv, er; logic [3:0] mbe;
      d_xfer(1'b1, 32'h10, 4'b1111, 32'h11223344, w, ma, mwe, mbe, rv, rd, er);
      d_xfer(1'b1, 32'h10, 4'b0010, 32'h0000AB00, w, ma, mwe, mbe, rv, rd, er);
      total++;
      if (mwe !== 1'b1 || mbe !== 4'b0010 || ma !== 32'h10) begin
         bad++; $display("FAIL pstore_grant: got we=%b be=%b addr=%h want 1 0010 10", mwe, mbe, ma);
      end
      total++;
      if (rv !== 1'b1 || rd !== 32'h11223344 || er !== 1'b0) begin
         bad++; $display("FAIL pstore_oldword: got rv=%b rdata=%h err=%b want 1 11223344 0", rv, rd, er);
      end
      d_xfer(1'b0, 32'h10, 4'b1111, 32'h0, w, ma, mwe, mbe, rv, rd, er);
      total++;
      if (mwe !== 1'b0 || rv !== 1'b1 || rd !== 32'h1122AB44) begin
         bad++; $display("FAIL pstore_dread: got we=%b rv=%b rdata=%h want 0 1 1122ab44", mwe, rv, rd);
      end
      i_xfer(32'h10, w, ma, mwe, mbe, rv, rd, er);
      total++;
      if (rv !== 1'b1 || rd !== 32'h1122AB44 || er !== 1'b0) begin
         bad++; $display("FAIL pstore_iread: got rv=%b rdata=%h err=%b want 1 1122ab44 0", rv, rd, er);
      end
   endtask

   // Entered right after a fetch grant, so round-robin starts with the data port.
   task automatic test_contention();
      logic [7:0] gi, gd, rvi, rvd;
      logic [7:0] exp_gi, exp_gd;
`ifdef ARB_RR_EN
      exp_gd = 8'b0001_0001; exp_gi = 8'b0100_0100;
`else
      exp_gd = 8'b0101_0101; exp_gi = 8'b0000_0000;
`endif
      @(posedge clk); #1;
      bus.i_valid = 1'b1; bus.i_addr = 32'h0C;
      bus.d_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10; bus.d_be = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         gi[k] = bus.i_ready; gd[k] = bus.d_ready; rvi[k] = bus.i_rvalid; rvd[k] = bus.d_rvalid;
      end
      @(posedge clk); #1;
      bus.i_valid = 1'b0; bus.d_valid = 1'b0;
      total++;
      if (gd !== exp_gd || gi !== exp_gi) begin
         bad++; $display("FAIL contention_grants: got d=%b i=%b want d=%b i=%b", gd, gi, exp_gd, exp_gi);
      end
      total++;
      if (rvd !== (exp_gd << 1) || rvi !== (exp_gi << 1)) begin
         bad++; $display("FAIL contention_rvalid: got d=%b i=%b want d=%b i=%b",
                         rvd, rvi, exp_gd << 1, exp_gi << 1);
      end
      total++;
      if ($countones(gd) != $countones(exp_gd) || $countones(gi) != $countones(exp_gi)) begin
         bad++; $display("FAIL contention_counts: got d=%0d i=%0d want d=%0d i=%0d",
                         $countones(gd), $countones(gi), $countones(exp_gd), $countones(exp_gi));
      end
   endtask

   task automatic test_out_of_range();
      int w; logic [31:0] ma, rd; logic mwe, rv, er; logic [3:0] mbe;
      d_xfer(1'b1, 32'hC8, 4'b1111, 32'hCAFEF00D, w, ma, mwe, mbe, rv, rd, er);
      total++;
      if (w != 0 || mwe !== 1'b0 || mbe !== 4'b0000) begin
         bad++; $display("FAIL oor_write_blocked: got wait=%0d we=%b be=%b want 0 0 0000", w, mwe, mbe);
      end
      total++;
      if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
         bad++; $display("FAIL oor_write_resp: got rv=%b err=%b rdata=%h want 1 1 0", rv, er, rd);
      end
      i_xfer(32'hC4, w, ma, mwe, mbe, rv, rd, er);
      total++;
      if (rv !== 1'b1 || er !== 1'b0 || mbe !== 4'b1111) begin
         bad++; $display("FAIL last_word_in_range: got rv=%b err=%b be=%b want 1 0 1111", rv, er, mbe);
      end
      i_xfer(32'hFFFF_FFFC, w, ma, mwe, mbe, rv, rd, er);
      total++;
      if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0 || mbe !== 4'b0000) begin
         bad++; $display("FAIL oor_fetch: got rv=%b err=%b rdata=%h be=%b want 1 1 0 0000", rv, er, rd, mbe);
      end
   endtask

   task automatic test_reset_in_resp();
      int w; logic [31:0] ma, rd; logic mwe, rv, er; logic [3:0] mbe;
      @(posedge clk); #1;
      bus.i_valid = 1'b1; bus.i_addr = 32'h0C;
      @(negedge clk);
      total++;
      if (bus.i_ready !== 1'b1) begin
         bad++; $display("FAIL rst_resp_grant: got i_ready=%b want 1", bus.i_ready);
      end
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      total++;
      if (bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'h0 || bus.mem_addr !== 32'h0) begin
         bad++; $display("FAIL rst_resp_clear: got rv=%b rdata=%h addr=%h want 0 0 0",
                         bus.i_rvalid, bus.i_rdata, bus.mem_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      i_xfer(32'h0C, w, ma, mwe, mbe, rv, rd, er);
      total++;
      if (w != 0 || rv !== 1'b1 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
         bad++; $display("FAIL rst_resp_after: got wait=%0d rv=%b rdata=%h err=%b want 0 1 deadbeef 0",
                         w, rv, rd, er);
      end
   endtask

   initial begin
      bus.i_valid = 1'b0; bus.i_addr = '0;
      bus.d_valid = 1'b0; bus.d_addr = '0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_wdata = '0;
      test_reset();
      test_fetch_read();
      test_partial_store();
      test_contention();
      test_out_of_range();
      test_reset_in_resp();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
